// File: rtl/mem_responder.sv
// Single-request load/store responder: word array serviced after WAIT_CYCLES wait states.
// Define MEM_BYTE_STROBE_EN to add the req_be_i port and per-byte-lane writes.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [3:0]  req_be_i,
`endif
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        busy_q;
    logic [31:0] mem_q [DEPTH];

    logic [3:0]       req_be_d;
    logic             accept;
    logic             enter_resp;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [3:0]       op_be;
    logic [IDX_W-1:0] op_idx;
    logic             op_err;

`ifdef MEM_BYTE_STROBE_EN
    assign req_be_d = req_be_i;
`else
    assign req_be_d = 4'hF;
`endif

    assign accept     = req_valid_i & req_ready_q;
    assign enter_resp = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

    // With zero wait states the access happens on the accept edge, before the capture registers load.
    always_comb begin
        op_we    = we_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_be    = be_q;
        if (state_q == S_IDLE) begin
            op_we    = req_we_i;
            op_addr  = req_addr_i;
            op_wdata = req_wdata_i;
            op_be    = req_be_d;
        end
    end

    assign op_idx = op_addr[IDX_W+1:2];
    assign op_err = (|op_addr[1:0]) | (|(op_addr >> (IDX_W + 2)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_d;
            end
            if (enter_resp) begin
                state_q     <= S_RESP;
                req_ready_q <= 1'b0;
                busy_q      <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= op_err;
                rsp_rdata_q <= (op_err || op_we) ? 32'd0 : mem_q[op_idx];
                if (!op_err && op_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (op_be[b]) begin
                            mem_q[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                        end
                    end
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_q     <= S_WAIT;
                            cnt_q       <= CNT_INIT;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_WAIT: cnt_q <= cnt_q - 4'd1;
                    S_RESP: begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a zero-wait and a one-wait instance checked every cycle against a request-level model.
// Byte-strobe vectors run only when MEM_BYTE_STROBE_EN is defined.
module tb_mem_responder;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
`ifdef MEM_BYTE_STROBE_EN
    logic [3:0]  req_be    [2];
`endif
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready[0]),
        .req_we_i    (req_we[0]),
        .req_addr_i  (req_addr[0]),
        .req_wdata_i (req_wdata[0]),
`ifdef MEM_BYTE_STROBE_EN
        .req_be_i    (req_be[0]),
`endif
        .rsp_valid_o (rsp_valid[0]),
        .rsp_rdata_o (rsp_rdata[0]),
        .rsp_err_o   (rsp_err[0]),
        .busy_o      (busy[0])
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready[1]),
        .req_we_i    (req_we[1]),
        .req_addr_i  (req_addr[1]),
        .req_wdata_i (req_wdata[1]),
`ifdef MEM_BYTE_STROBE_EN
        .req_be_i    (req_be[1]),
`endif
        .rsp_valid_o (rsp_valid[1]),
        .rsp_rdata_o (rsp_rdata[1]),
        .rsp_err_o   (rsp_err[1]),
        .busy_o      (busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request-level model: each accepted request is resolved immediately against a plain
    // word array; the response is due wait+1 cycles later and the port is free again after wait+2.
    int          wait_of   [2] = '{0, 1};
    int          next_acc  [2] = '{0, 0};
    int          rsp_edge  [2] = '{-1, -1};
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];
    logic [31:0] mem_m     [2][DEPTH];

    always @(posedge clk) begin
        int          e;
        logic [31:0] a;
        logic [31:0] mask;
        logic [3:0]  be;
        logic        ev;
        e = cyc;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'd0;
                next_acc[d]  = e;
                rsp_edge[d]  = -1;
                exp_rdata[d] = 32'd0;
                exp_err[d]   = 1'b0;
            end else if (req_valid[d] && e >= next_acc[d]) begin
                a = req_addr[d];
`ifdef MEM_BYTE_STROBE_EN
                be = req_be[d];
`else
                be = 4'hF;
`endif
                mask = 32'd0;
                for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
                exp_err[d] = (a % 4 != 0) || (a >= DEPTH * 4);
                exp_rdata[d] = 32'd0;
                if (!exp_err[d]) begin
                    if (req_we[d]) mem_m[d][a / 4] = (mem_m[d][a / 4] & ~mask) | (req_wdata[d] & mask);
                    else exp_rdata[d] = mem_m[d][a / 4];
                end
                rsp_edge[d] = e + wait_of[d];
                next_acc[d] = e + wait_of[d] + 2;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            ev = rst_n && (e == rsp_edge[d]);
            chk($sformatf("dut%0d_ready", d), {31'd0, req_ready[d]}, {31'd0, !rst_n || (e + 1 >= next_acc[d])});
            chk($sformatf("dut%0d_busy", d), {31'd0, busy[d]}, {31'd0, rst_n && (e + 1 < next_acc[d])});
            chk($sformatf("dut%0d_rsp_valid", d), {31'd0, rsp_valid[d]}, {31'd0, ev});
            chk($sformatf("dut%0d_rsp_rdata", d), rsp_rdata[d], ev ? exp_rdata[d] : 32'd0);
            chk($sformatf("dut%0d_rsp_err", d), {31'd0, rsp_err[d]}, {31'd0, ev && exp_err[d]});
        end
    end

    task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
`ifdef MEM_BYTE_STROBE_EN
        req_be[d]    = be;
`endif
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut%0d got ready=0 for 20 cycles expected ready=1", d);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: dut%0d got no rsp_valid in 40 cycles expected a response", d);
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        $display("xact dut%0d %s addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
                 d, we ? "WR" : "RD", addr, wdata, be, rdata, err, lat);
    endtask

    logic [31:0] b2b_val [4] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
`ifdef MEM_BYTE_STROBE_EN
            req_be[d]    = 4'hF;
`endif
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, req_ready[1]}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("rst_busy", {31'd0, busy[1]}, 32'd0);

        xact(1, 1'b0, 32'h10, 32'd0, 4'hF, rd, er, lat);
        chk("rd10_data", rd, 32'd0);
        chk("rd10_err", {31'd0, er}, 32'd0);
        chk("rd10_lat", lat, 2);

        xact(1, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("wr08_data", rd, 32'd0);
        chk("wr08_err", {31'd0, er}, 32'd0);
        chk("wr08_lat", lat, 2);
        xact(1, 1'b0, 32'h08, 32'd0, 4'hF, rd, er, lat);
        chk("rd08_data", rd, 32'hDEADBEEF);
        chk("rd08_lat", lat, 2);

        xact(1, 1'b0, 32'h0A, 32'd0, 4'hF, rd, er, lat);
        chk("rd0a_err", {31'd0, er}, 32'd1);
        chk("rd0a_data", rd, 32'd0);
        xact(1, 1'b0, DEPTH * 4, 32'd0, 4'hF, rd, er, lat);
        chk("rd_oor_err", {31'd0, er}, 32'd1);
        chk("rd_oor_data", rd, 32'd0);
        xact(1, 1'b0, 32'h8000_0008, 32'd0, 4'hF, rd, er, lat);
        chk("rd_high_err", {31'd0, er}, 32'd1);
        xact(1, 1'b1, 32'h0A, 32'h1111_1111, 4'hF, rd, er, lat);
        chk("wr0a_err", {31'd0, er}, 32'd1);
        xact(1, 1'b0, 32'h08, 32'd0, 4'hF, rd, er, lat);
        chk("rd08_after_bad_wr", rd, 32'hDEADBEEF);
        xact(1, 1'b0, DEPTH * 4 - 4, 32'd0, 4'hF, rd, er, lat);
        chk("rd_last_err", {31'd0, er}, 32'd0);

        xact(0, 1'b0, 32'h10, 32'd0, 4'hF, rd, er, lat);
        chk("w0_rd_lat", lat, 1);
        chk("w0_rd_err", {31'd0, er}, 32'd0);

        // Back-to-back on the zero-wait instance with req_valid held high throughout.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'd0;
        req_wdata[0] = b2b_val[0];
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready_idle", {31'd0, req_ready[0]}, 32'd1);
            @(negedge clk);
            chk("b2b_ready_after_accept", {31'd0, req_ready[0]}, 32'd0);
            chk("b2b_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            if (i >= 4) chk("b2b_rdata", rsp_rdata[0], b2b_val[i - 4]);
            $display("xact dut0 b2b %s addr=%h -> rdata=%h err=%0d",
                     req_we[0] ? "WR" : "RD", req_addr[0], rsp_rdata[0], rsp_err[0]);
            if (i < 7) begin
                req_we[0]    = (i + 1 < 4);
                req_addr[0]  = 32'(4 * ((i + 1) % 4));
                req_wdata[0] = b2b_val[(i + 1) % 4];
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
        end

        // Reset in the middle of a write's wait state.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h04;
        req_wdata[1] = 32'h1234_5678;
        chk("abort_ready", {31'd0, req_ready[1]}, 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("abort_busy_in_wait", {31'd0, busy[1]}, 32'd1);
        chk("abort_valid_in_wait", {31'd0, rsp_valid[1]}, 32'd0);
        $display("xact dut1 WR addr=00000004 wdata=12345678 aborted by reset");
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp_in_reset", {31'd0, rsp_valid[1]}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp_after", {31'd0, rsp_valid[1]}, 32'd0);
        end
        xact(1, 1'b0, 32'h04, 32'd0, 4'hF, rd, er, lat);
        chk("abort_rd04", rd, 32'd0);
        xact(1, 1'b0, 32'h08, 32'd0, 4'hF, rd, er, lat);
        chk("rst_cleared_rd08", rd, 32'd0);

`ifdef MEM_BYTE_STROBE_EN
        xact(1, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        xact(1, 1'b1, 32'h00, 32'h0000_0000, 4'b0101, rd, er, lat);
        chk("be_wr_err", {31'd0, er}, 32'd0);
        xact(1, 1'b0, 32'h00, 32'd0, 4'b0000, rd, er, lat);
        chk("be_rd", rd, 32'hFF00_FF00);
        xact(1, 1'b1, 32'h00, 32'h1234_5678, 4'b0000, rd, er, lat);
        chk("be_noop_err", {31'd0, er}, 32'd0);
        xact(1, 1'b0, 32'h00, 32'd0, 4'b0000, rd, er, lat);
        chk("be_noop_rd", rd, 32'hFF00_FF00);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no finish by 200000 expected finish earlier");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
